strobe_sample_driver: RTL and testbench
=======================================

Name: strobe_sample_driver

Overview:
- Transmitter-side partner for the strobe-handshaked sample filter.
- Generates 8-bit samples and presents them with a one-cycle strobe at a programmable period.
- Holds each sample stable until the filter returns its done strobe, then captures the filter result.
- Used as the on-chip stimulus source and result collector in front of the moving-average path; also counts transactions and flags timeouts.

Parameters:
- DATA_W, 8, sample and result width.
- DIV_W, 8, width of the period counter and of period_i.
- TIMEOUT, 15, maximum cycles in WAIT_DONE before abort; must be at least 8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enable_i  in  1  run request; level sensitive
- mode_i  in  2  sample source: 00 constant, 01 ramp, 10 LFSR, 11 constant
- const_i  in  DATA_W  value used in constant mode
- period_i  in  DIV_W  IDLE cycles between transactions; 0 is treated as 1
- data_o  out  DATA_W  sample to filter data input
- strobe_o  out  1  one-cycle sample strobe to filter
- done_i  in  1  filter strobe output (completion pulse)
- result_i  in  DATA_W  filter average output
- result_o  out  DATA_W  last captured result
- result_valid_o  out  1  one-cycle pulse when result_o updates
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  sticky abort flag; cleared only by reset
- sample_count_o  out  8  completed transactions, wraps 255 to 0

Behaviour:
- Reset (async, active-high) values:
  - All outputs are 0.
  - State is IDLE; period counter, ramp and wait counter are 0.
  - LFSR is 8'h01.
- States: IDLE, ISSUE, WAIT_DONE, CAPTURE.
- IDLE:
  - While enable_i=1, the period counter increments each cycle.
  - When it reaches max(period_i,1), go to ISSUE and clear the counter.
  - While enable_i=0, the counter holds at 0.
- ISSUE (1 cycle):
  - strobe_o=1.
  - data_o is loaded from the selected source on entry (registered, so valid in the same cycle as strobe_o).
  - Go to WAIT_DONE with the wait counter cleared.
- WAIT_DONE:
  - data_o is held unchanged; the filter re-samples data during its average phase, so data_o must stay stable through done_i.
  - done_i=1 -> go to CAPTURE.
  - Otherwise the wait counter increments; at TIMEOUT, set timeout_o, go to IDLE, emit no result_valid_o, leave sample_count_o unchanged.
- CAPTURE (1 cycle): the filter output register updates one cycle after its done strobe, so result_i is sampled here.
  - result_o<=result_i, result_valid_o=1 for this cycle.
  - sample_count_o increments; go to IDLE.
- Sources:
  - Ramp and LFSR advance exactly once per ISSUE, after their value is used.
  - Ramp is +1 mod 2^DATA_W.
  - LFSR is Fibonacci x^8+x^6+x^5+x^4+1 (taps 7,5,4,3, shift left, feedback into bit 0); it never reaches 0.
  - Constant mode samples const_i on the ISSUE cycle.
- mode_i changes take effect at the next ISSUE; unused generators hold their state.
- enable_i dropping mid-transaction: the current transaction completes (or times out), then the block stays in IDLE.
- done_i in IDLE, ISSUE or CAPTURE is ignored.
- done_i in the same cycle as the timeout threshold: done wins, so capture happens and timeout_o is not set.
- Reset mid-transaction: immediate return to reset values; strobe_o drops asynchronously.
- Throughput: with period_i=1 and the filter responding in N cycles, one transaction takes 1 IDLE + 1 ISSUE + N WAIT_DONE + 1 CAPTURE cycles.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT_DONE=2'b10, CAPTURE=2'b11);
  - mode constants;
  - LFSR seed and tap mask;
  - DATA_W default.
- One natural sub-module, sample_gen: the ramp, LFSR and constant mux with an advance input. The FSM, counters and capture logic stay in the top module.

Test Plan:
- Reset then enable_i=1, mode=00, const_i=8'h40, period_i=3 -> first strobe_o in the 4th cycle after enable; data_o=8'h40 held until done_i. Filter model returns done_i after 6 cycles with result_i=8'h10 -> result_o=8'h10, result_valid_o single pulse, sample_count_o=1.
- Ramp mode, 4 transactions against the real moving-average filter -> data_o sequence 0,1,2,3 and result_o sequence 0,0,0,1. Check the last value: (0+1+2+3)/4=1.
- LFSR mode, 5 transactions -> data_o sequence 01,02,04,08,11 (per the tap definition).
- done_i never asserted, TIMEOUT=15 -> after 15 WAIT_DONE cycles timeout_o=1 (sticky), no result_valid_o, sample_count_o unchanged, next ISSUE still occurs.
- enable_i dropped during WAIT_DONE -> transaction completes with one result_valid_o, then busy_o=0 and no further strobe_o. Assert reset during WAIT_DONE -> all outputs 0 immediately.
- period_i=0, ramp at 8'hFF -> one IDLE cycle between transactions; ramp wraps to 8'h00; sample_count_o wraps 255 to 0.

Source files
------------

// File: rtl/strobe_sample_driver_pkg.sv
// Shared definitions for the strobe sample driver: state encoding, source modes
// and the LFSR polynomial used by the sample generator.
package strobe_sample_driver_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_CAPTURE   = 2'b11
    } state_t;

    localparam logic [1:0] MODE_CONST     = 2'b00;
    localparam logic [1:0] MODE_RAMP      = 2'b01;
    localparam logic [1:0] MODE_LFSR      = 2'b10;
    localparam logic [1:0] MODE_CONST_ALT = 2'b11;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // x^8+x^6+x^5+x^4+1 expressed as taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/strobe_sample_driver_if.sv
// Strobe/done handshake between the sample driver (master) and the filter (slave).
interface strobe_sample_driver_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data_o;
    logic              strobe_o;
    logic              done_i;
    logic [DATA_W-1:0] result_i;

    modport master (
        output data_o,
        output strobe_o,
        input  done_i,
        input  result_i
    );

    modport slave (
        input  data_o,
        input  strobe_o,
        output done_i,
        output result_i
    );

endinterface

// File: rtl/strobe_sample_driver_sample_gen.sv
// Sample sources for the driver: constant, ramp and LFSR. Only the generator
// selected by mode advances, and only when advance is pulsed.
module strobe_sample_driver_sample_gen
    import strobe_sample_driver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic              advance,
    output logic [DATA_W-1:0] sample
);

    logic [DATA_W-1:0] ramp_r;
    logic [7:0]        lfsr_r;
    logic [DATA_W-1:0] lfsr_ext_s;

    assign lfsr_ext_s = DATA_W'(lfsr_r);

    // Ramp generator: steps by one after each sample it supplied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_r <= {DATA_W{1'b0}};
        end else if (advance && (mode == MODE_RAMP)) begin
            ramp_r <= ramp_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            ramp_r <= ramp_r;
        end
    end

    // LFSR generator: seeded non-zero, so the sequence never locks up at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (advance && (mode == MODE_LFSR)) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Source mux; both constant encodings select const_val.
    always_comb begin
        sample = const_val;
        case (mode)
            MODE_RAMP:      sample = ramp_r;
            MODE_LFSR:      sample = lfsr_ext_s;
            MODE_CONST:     sample = const_val;
            MODE_CONST_ALT: sample = const_val;
            default:        sample = const_val;
        endcase
    end

endmodule

// File: rtl/strobe_sample_driver.sv
// Stimulus source and result collector for the strobe-handshaked sample filter:
// issues samples at a programmable period, waits for done, captures the result.
module strobe_sample_driver
    import strobe_sample_driver_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DIV_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_W-1:0]     const_i,
    input  logic [DIV_W-1:0]      period_i,
    strobe_sample_driver_if.master filt,
    output logic [DATA_W-1:0]     result_o,
    output logic                  result_valid_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [7:0]            sample_count_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_r;
    state_t              state_s;
    logic [DIV_W-1:0]    period_cnt_r;
    logic [DIV_W-1:0]    period_cnt_s;
    logic [DIV_W:0]      period_inc_s;
    logic [DIV_W-1:0]    period_eff_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_s;
    logic [WAIT_W-1:0]   wait_inc_s;
    logic                issue_s;
    logic                capture_s;
    logic                abort_s;
    logic [DATA_W-1:0]   sample_s;
    logic [DATA_W-1:0]   data_r;
    logic                strobe_r;
    logic                busy_r;
    logic [DATA_W-1:0]   result_r;
    logic                valid_r;
    logic                timeout_r;
    logic [7:0]          count_r;

    strobe_sample_driver_sample_gen #(
        .DATA_W (DATA_W)
    ) u_sample_gen (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode_i),
        .const_val (const_i),
        .advance   (issue_s),
        .sample    (sample_s)
    );

    assign period_eff_s = (period_i == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : period_i;
    assign period_inc_s = {1'b0, period_cnt_r} + {{DIV_W{1'b0}}, 1'b1};
    assign wait_inc_s   = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};

    // Next-state logic; issue/capture/abort flag the transitions the datapath acts on.
    always_comb begin
        state_s      = state_r;
        period_cnt_s = period_cnt_r;
        wait_cnt_s   = wait_cnt_r;
        issue_s      = 1'b0;
        capture_s    = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!enable_i) begin
                    period_cnt_s = {DIV_W{1'b0}};
                end else if (period_inc_s == {1'b0, period_eff_s}) begin
                    period_cnt_s = {DIV_W{1'b0}};
                    state_s      = ST_ISSUE;
                    issue_s      = 1'b1;
                end else begin
                    period_cnt_s = period_inc_s[DIV_W-1:0];
                end
            end
            ST_ISSUE: begin
                state_s    = ST_WAIT_DONE;
                wait_cnt_s = {WAIT_W{1'b0}};
            end
            ST_WAIT_DONE: begin
                // done on the threshold cycle still counts as a completion
                if (filt.done_i) begin
                    state_s = ST_CAPTURE;
                end else if (wait_inc_s == WAIT_W'(TIMEOUT)) begin
                    state_s    = ST_IDLE;
                    wait_cnt_s = {WAIT_W{1'b0}};
                    abort_s    = 1'b1;
                end else begin
                    wait_cnt_s = wait_inc_s;
                end
            end
            ST_CAPTURE: begin
                state_s   = ST_IDLE;
                capture_s = 1'b1;
            end
            default: begin
                state_s      = ST_IDLE;
                period_cnt_s = {DIV_W{1'b0}};
                wait_cnt_s   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= {DIV_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            period_cnt_r <= period_cnt_s;
            wait_cnt_r   <= wait_cnt_s;
        end
    end

    // Handshake outputs: the sample is loaded on ISSUE entry and held until the next ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r   <= {DATA_W{1'b0}};
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            data_r   <= issue_s ? sample_s : data_r;
            strobe_r <= (state_s == ST_ISSUE);
            busy_r   <= (state_s != ST_IDLE);
        end
    end

    // Result capture, transaction count and sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r  <= {DATA_W{1'b0}};
            valid_r   <= 1'b0;
            count_r   <= 8'h00;
            timeout_r <= 1'b0;
        end else begin
            valid_r   <= capture_s;
            result_r  <= capture_s ? filt.result_i : result_r;
            count_r   <= capture_s ? (count_r + 8'h01) : count_r;
            timeout_r <= timeout_r | abort_s;
        end
    end

    assign filt.data_o    = data_r;
    assign filt.strobe_o  = strobe_r;
    assign result_o       = result_r;
    assign result_valid_o = valid_r;
    assign busy_o         = busy_r;
    assign timeout_o      = timeout_r;
    assign sample_count_o = count_r;

endmodule

// File: tb/tb_strobe_sample_driver.sv
// Self-checking bench: a filter responder, a timeline model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_strobe_sample_driver;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic [7:0] const_i = 8'h00;
    logic [7:0] period_i = 8'h01;
    logic [7:0] result_o;
    logic       result_valid_o;
    logic       busy_o;
    logic       timeout_o;
    logic [7:0] sample_count_o;

    strobe_sample_driver_if #(.DATA_W(8)) sif ();

    strobe_sample_driver #(.DATA_W(8), .DIV_W(8), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_i       (enable_i),
        .mode_i         (mode_i),
        .const_i        (const_i),
        .period_i       (period_i),
        .filt           (sif),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .sample_count_o (sample_count_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Filter responder: done_i d cycles after the strobe, result one cycle later.
    bit         resp_on = 1'b0;
    bit         resp_avg = 1'b0;
    int         resp_delay = 6;
    logic [7:0] resp_fixed = 8'h00;
    int         hist [4];

    initial begin
        sif.done_i   = 1'b0;
        sif.result_i = 8'h00;
        forever begin
            @(negedge clk);
            if (resp_on && !reset && sif.strobe_o === 1'b1) begin
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(sif.data_o);
                repeat (resp_delay) @(negedge clk);
                sif.done_i = 1'b1;
                @(negedge clk);
                sif.done_i = 1'b0;
                sif.result_i = resp_avg ? 8'((hist[0] + hist[1] + hist[2] + hist[3]) / 4) : resp_fixed;
            end
        end
    end

    // Timeline model and logs; observation at posedge+1 sees inputs as the DUT sampled them.
    int         cyc = 0;
    bit         m_in, m_got, m_to, e_strobe, e_valid;
    int         m_run, m_s, m_done, m_cnt, m_ramp, m_lfsr, per, fb;
    logic [7:0] m_res, m_held;
    int         sc_q [$];
    logic [7:0] sd_q [$];
    int         vc_q [$];
    logic [7:0] vr_q [$];
    logic [7:0] vn_q [$];
    int         to_cyc = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            m_in = 0; m_got = 0; m_to = 0; m_run = 0; m_cnt = 0;
            m_ramp = 0; m_lfsr = 1; m_res = 8'h00; m_held = 8'h00;
            chk("rst strobe_o", sif.strobe_o, 1'b0);
            chk("rst data_o", sif.data_o, 8'h00);
            chk("rst busy_o", busy_o, 1'b0);
            chk("rst result_valid_o", result_valid_o, 1'b0);
            chk("rst result_o", result_o, 8'h00);
            chk("rst timeout_o", timeout_o, 1'b0);
            chk("rst sample_count_o", sample_count_o, 8'h00);
        end else begin
            e_strobe = 0;
            e_valid  = 0;
            per = (period_i == 8'h00) ? 1 : int'(period_i);
            if (!m_in) begin
                if (enable_i) m_run++; else m_run = 0;
                if (m_run == per) begin
                    m_run = 0; m_in = 1; m_got = 0; m_s = cyc; e_strobe = 1;
                    case (mode_i)
                        2'b01: begin m_held = 8'(m_ramp); m_ramp = (m_ramp + 1) % 256; end
                        2'b10: begin
                            m_held = 8'(m_lfsr);
                            fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                            m_lfsr = ((m_lfsr << 1) & 255) | fb;
                        end
                        default: m_held = const_i;
                    endcase
                end
            end else if (!m_got && (cyc - 1 > m_s)) begin
                if (sif.done_i) begin
                    m_got = 1; m_done = cyc - 1;
                end else if (cyc - 1 - m_s == TO) begin
                    m_to = 1; m_in = 0; to_cyc = cyc;
                end
            end else if (m_got && cyc == m_done + 2) begin
                e_valid = 1; m_res = sif.result_i; m_cnt = (m_cnt + 1) % 256; m_in = 0; m_got = 0;
            end
            chk("strobe_o", sif.strobe_o, e_strobe);
            chk("data_o", sif.data_o, m_held);
            chk("busy_o", busy_o, m_in);
            chk("result_valid_o", result_valid_o, e_valid);
            chk("result_o", result_o, m_res);
            chk("timeout_o", timeout_o, m_to);
            chk("sample_count_o", sample_count_o, m_cnt);
            if (sif.strobe_o === 1'b1) begin sc_q.push_back(cyc); sd_q.push_back(sif.data_o); end
            if (result_valid_o === 1'b1) begin
                vc_q.push_back(cyc); vr_q.push_back(result_o); vn_q.push_back(sample_count_o);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable_i = 1'b0; resp_on = 1'b0;
        sc_q.delete(); sd_q.delete(); vc_q.delete(); vr_q.delete(); vn_q.delete();
        foreach (hist[i]) hist[i] = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && sc_q.size() < n; i++) @(negedge clk);
        chk("strobe count reached", (sc_q.size() >= n), 1'b1);
    endtask

    task automatic wait_valids(input int n, input int budget);
        for (int i = 0; i < budget && vc_q.size() < n; i++) @(negedge clk);
        chk("valid count reached", (vc_q.size() >= n), 1'b1);
    endtask

    logic [7:0] exp_ramp_d [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0] exp_ramp_r [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] exp_lfsr [5]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    int en_c;

    initial begin
        #1 reset = 1'b1;

        // Constant mode, period 3, done after 6 cycles; enable dropped mid-wait.
        do_reset();
        mode_i = 2'b00; const_i = 8'h40; period_i = 8'd3;
        resp_avg = 1'b0; resp_fixed = 8'h10; resp_delay = 6; resp_on = 1'b1;
        enable_i = 1'b1; en_c = cyc;
        wait_strobes(1, 20);
        repeat (2) @(negedge clk);
        enable_i = 1'b0;
        wait_valids(1, 40);
        repeat (30) @(negedge clk);
        chk("t1 first strobe delay", sc_q[0] - en_c, 3);
        chk("t1 data", sd_q[0], 8'h40);
        chk("t1 result", vr_q[0], 8'h10);
        chk("t1 count", vn_q[0], 8'h01);
        chk("t1 valid latency", vc_q[0] - sc_q[0], 8);
        chk("t1 single strobe", sc_q.size(), 1);
        chk("t1 single valid", vc_q.size(), 1);
        chk("t1 idle busy", busy_o, 1'b0);

        // Ramp against a 4-tap moving average, done after 3 cycles.
        do_reset();
        mode_i = 2'b01; period_i = 8'd1;
        resp_avg = 1'b1; resp_delay = 3; resp_on = 1'b1;
        enable_i = 1'b1;
        wait_valids(4, 100);
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t2 ramp data", sd_q[i], exp_ramp_d[i]);
            chk("t2 avg result", vr_q[i], exp_ramp_r[i]);
        end
        chk("t2 txn period", sc_q[1] - sc_q[0], 6);

        // LFSR sequence.
        do_reset();
        mode_i = 2'b10; period_i = 8'd2;
        resp_avg = 1'b0; resp_fixed = 8'h5A; resp_delay = 2; resp_on = 1'b1;
        enable_i = 1'b1;
        wait_valids(5, 150);
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) chk("t3 lfsr data", sd_q[i], exp_lfsr[i]);

        // Timeout with no done, then asynchronous reset mid-transaction.
        do_reset();
        mode_i = 2'b00; const_i = 8'hA5; period_i = 8'd2;
        enable_i = 1'b1;
        wait_strobes(1, 20);
        for (int i = 0; i < 40 && timeout_o !== 1'b1; i++) @(negedge clk);
        chk("t4 timeout set", timeout_o, 1'b1);
        chk("t4 timeout delay", to_cyc - sc_q[0], 16);
        chk("t4 no result", vc_q.size(), 0);
        chk("t4 count kept", sample_count_o, 8'h00);
        wait_strobes(2, 20);
        chk("t4 reissue gap", sc_q[1] - to_cyc, 2);
        chk("t4 timeout sticky", timeout_o, 1'b1);
        chk("t4 strobe before reset", sif.strobe_o, 1'b1);
        reset = 1'b1;
        #1;
        chk("t4 async strobe", sif.strobe_o, 1'b0);
        chk("t4 async data", sif.data_o, 8'h00);
        chk("t4 async busy", busy_o, 1'b0);
        chk("t4 async timeout", timeout_o, 1'b0);

        // Period 0, ramp wrap at FF and count wrap 255 -> 0.
        do_reset();
        mode_i = 2'b01; period_i = 8'd0;
        resp_avg = 1'b0; resp_fixed = 8'h33; resp_delay = 1; resp_on = 1'b1;
        enable_i = 1'b1;
        wait_valids(257, 1400);
        enable_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5 ramp at FF", sd_q[255], 8'hFF);
        chk("t5 ramp wrap", sd_q[256], 8'h00);
        chk("t5 count 255", vn_q[254], 8'hFF);
        chk("t5 count wrap", vn_q[255], 8'h00);
        chk("t5 count after wrap", vn_q[256], 8'h01);
        chk("t5 txn period", sc_q[1] - sc_q[0], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
